// File: rtl/dma_tx_rq_buf_if.sv
// Beat stream between the DMA TX request mux, the request buffer and the PCIe RQ interface.
// The master drives valid/last/data and the slave returns ready.
interface dma_tx_rq_buf_if #(
  parameter int DW = 512
);
  logic          tvalid;
  logic          tlast;
  logic [DW-1:0] tdata;
  logic          tready;

  modport master (output tvalid, tlast, tdata, input  tready);
  modport slave  (input  tvalid, tlast, tdata, output tready);
endinterface

// File: rtl/dma_tx_rq_buf.sv
// Small request buffer ahead of the PCIe RQ interface. It returns a pop toggle to the mux,
// stops only at packet boundaries on tx_hold, and flags output packets that run too long.
module dma_tx_rq_buf #(
  parameter int DEPTH         = 3,
  parameter int MAX_PKT_BEATS = 16,
  parameter int DW            = 512
) (
  input  logic                  user_clk,
  input  logic                  reset_n,
  dma_tx_rq_buf_if.slave        rq_in,
  dma_tx_rq_buf_if.master       rq_out,
  output logic                  trx_fifo_rd_ptr,
  input  logic                  tx_hold,
  output logic [1:0]            fifo_cnt,
  output logic                  pkt_active,
  output logic                  len_err,
  input  logic                  err_clr
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = $clog2(MAX_PKT_BEATS + 1);

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  typedef enum logic {IDLE, IN_PKT} state_t;

  beat_t          mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [BW-1:0]  beat_cnt;
  state_t         state;
  logic           offered;
  logic           push, pop, head_last;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready comes from the registered count only, so tready_out never reaches tready_in.
  assign rq_in.tready = (fifo_cnt < 2'(DEPTH));
  assign push         = rq_in.tvalid && rq_in.tready;

  // An offered beat stays valid until taken, even if tx_hold rises meanwhile.
  assign rq_out.tvalid = (fifo_cnt != 2'd0) && ((state == IN_PKT) || !tx_hold || offered);
  assign pop           = rq_out.tvalid && rq_out.tready;
  assign head_last     = mem[rd_ptr].last;
  assign rq_out.tlast  = head_last;
  assign rq_out.tdata  = mem[rd_ptr].data;
  assign pkt_active    = (state == IN_PKT);

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{last: rq_in.tlast, data: rq_in.tdata};
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
      trx_fifo_rd_ptr <= 1'b0;
      state           <= IDLE;
      beat_cnt        <= '0;
      len_err         <= 1'b0;
      offered         <= 1'b0;
    end else begin
      offered <= rq_out.tvalid && !rq_out.tready;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr          <= ptr_inc(rd_ptr);
        trx_fifo_rd_ptr <= ~trx_fifo_rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      case (state)
        IDLE:    if (pop && !head_last) state <= IN_PKT;
        IN_PKT:  if (pop && head_last)  state <= IDLE;
        default: state <= IDLE;
      endcase

      if (pop) begin
        if (head_last)                            beat_cnt <= '0;
        else if (beat_cnt != BW'(MAX_PKT_BEATS))  beat_cnt <= beat_cnt + 1'b1;
      end

      // A fresh overrun beats a same-cycle clear.
      if (pop && !head_last && (beat_cnt == BW'(MAX_PKT_BEATS - 1))) len_err <= 1'b1;
      else if (err_clr)                                              len_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dma_tx_rq_buf.sv
// Randomized and directed bench for dma_tx_rq_buf against a queue-based packet model.
module tb_dma_tx_rq_buf;
  localparam int DEPTH = 3;
  localparam int MAXB  = 16;

  logic       user_clk = 1'b0;
  logic       reset_n  = 1'b0;
  logic       tx_hold  = 1'b0;
  logic       err_clr  = 1'b0;
  logic       trx_fifo_rd_ptr;
  logic [1:0] fifo_cnt;
  logic       pkt_active, len_err;

  dma_tx_rq_buf_if #(.DW(512)) rq_in ();
  dma_tx_rq_buf_if #(.DW(512)) rq_out ();

  dma_tx_rq_buf #(.DEPTH(DEPTH), .MAX_PKT_BEATS(MAXB), .DW(512)) dut (
    .user_clk        (user_clk),
    .reset_n         (reset_n),
    .rq_in           (rq_in),
    .rq_out          (rq_out),
    .trx_fifo_rd_ptr (trx_fifo_rd_ptr),
    .tx_hold         (tx_hold),
    .fifo_cnt        (fifo_cnt),
    .pkt_active      (pkt_active),
    .len_err         (len_err),
    .err_clr         (err_clr)
  );

  always #5 user_clk = ~user_clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Model: the buffer is a queue; a packet is "open" after any non-last beat leaves.
  typedef struct { logic last; logic [511:0] data; } mb_t;
  mb_t q[$];
  bit  m_inpkt = 0, m_offer = 0, m_rd = 0, m_err = 0;
  int  m_beats = 0;

  always @(negedge user_clk) begin
    int  ec;
    bit  ev, er, mpop, mpush;
    mb_t b;
    if (!reset_n) begin
      q.delete();
      m_inpkt = 0; m_offer = 0; m_rd = 0; m_err = 0; m_beats = 0;
    end
    ec = q.size();
    er = (ec < DEPTH);
    ev = (ec != 0) && (m_inpkt || !tx_hold || m_offer);
    chk("tready_in",  rq_in.tready,    er);
    chk("tvalid_out", rq_out.tvalid,   ev);
    chk("fifo_cnt",   fifo_cnt,        ec);
    chk("pkt_active", pkt_active,      m_inpkt);
    chk("len_err",    len_err,         m_err);
    chk("rd_ptr",     trx_fifo_rd_ptr, m_rd);
    if (ec != 0) begin
      chk("tdata_out", rq_out.tdata, q[0].data);
      chk("tlast_out", rq_out.tlast, q[0].last);
    end else if (!reset_n) begin
      chk("tdata_rst", rq_out.tdata, '0);
    end
    if (reset_n) begin
      mpop  = ev && (rq_out.tready === 1'b1);
      mpush = (rq_in.tvalid === 1'b1) && er;
      m_offer = ev && (rq_out.tready !== 1'b1);
      if (mpop && !q[0].last && m_beats == MAXB - 1) m_err = 1;
      else if (err_clr)                              m_err = 0;
      if (mpop) begin
        b = q.pop_front();
        m_rd    = !m_rd;
        m_inpkt = !b.last;
        m_beats = b.last ? 0 : ((m_beats < MAXB) ? m_beats + 1 : MAXB);
      end
      if (mpush) q.push_back('{last: rq_in.tlast, data: rq_in.tdata});
    end
  end

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic send(input logic lst, input logic [511:0] d);
    int   n = 0;
    logic acc;
    rq_in.tvalid = 1'b1; rq_in.tlast = lst; rq_in.tdata = d;
    do begin
      acc = rq_in.tready;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_accept", acc, 1'b1);
    rq_in.tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rq_out.tready = 1'b1; tx_hold = 1'b0;
    while (fifo_cnt != 2'd0 && n < 100) begin tick(); n++; end
    chk("drain_empty", fifo_cnt, 2'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] d;
    rq_in.tvalid = 1'b0; rq_in.tlast = 1'b0; rq_in.tdata = '0;
    rq_out.tready = 1'b0;
    tick(); tick();
    chk("reset_cnt",  fifo_cnt, 2'd0);
    chk("reset_vld",  rq_out.tvalid, 1'b0);
    reset_n = 1'b1;

    // Single beat straight through
    rq_out.tready = 1'b1;
    d = rnd512();
    rq_in.tvalid = 1'b1; rq_in.tlast = 1'b1; rq_in.tdata = d;
    chk("t1_no_bypass", rq_out.tvalid, 1'b0);
    tick(); rq_in.tvalid = 1'b0;
    chk("t1_vld",  rq_out.tvalid, 1'b1);
    chk("t1_data", rq_out.tdata, d);
    chk("t1_ptr0", trx_fifo_rd_ptr, 1'b0);
    tick();
    chk("t1_ptr1", trx_fifo_rd_ptr, 1'b1);
    chk("t1_cnt",  fifo_cnt, 2'd0);

    // Backpressure: fourth beat waits at the input
    rq_out.tready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1, rnd512());
    chk("t2_full_cnt", fifo_cnt, 2'd3);
    chk("t2_full_rdy", rq_in.tready, 1'b0);
    d = rnd512();
    rq_in.tvalid = 1'b1; rq_in.tlast = 1'b1; rq_in.tdata = d;
    tick(); tick();
    chk("t2_held_cnt", fifo_cnt, 2'd3);
    rq_out.tready = 1'b1;
    send(1'b1, d);
    drain();
    chk("t2_ptr_after4", trx_fifo_rd_ptr, 1'b1);

    // Full buffer with push and pop both requested
    rq_out.tready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1, rnd512());
    rq_out.tready = 1'b1;
    rq_in.tvalid = 1'b1; rq_in.tlast = 1'b1; rq_in.tdata = rnd512();
    tick();
    chk("t3_cnt_after_pop", fifo_cnt, 2'd2);
    for (int i = 0; i < 5; i++) begin rq_in.tdata = rnd512(); tick(); end
    rq_in.tvalid = 1'b0;
    drain();

    // tx_hold raised mid-packet
    rq_out.tready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, rnd512());
    rq_out.tready = 1'b1;
    tick();
    chk("t4_inpkt", pkt_active, 1'b1);
    tx_hold = 1'b1;
    send(1'b1, rnd512());
    send(1'b1, rnd512());
    repeat (6) tick();
    chk("t4_held_cnt", fifo_cnt, 2'd1);
    chk("t4_held_vld", rq_out.tvalid, 1'b0);
    chk("t4_idle",     pkt_active, 1'b0);
    tx_hold = 1'b0;
    #1;
    chk("t4_release_vld", rq_out.tvalid, 1'b1);
    drain();

    // Packet length limit
    rq_out.tready = 1'b1;
    for (int i = 0; i < 17; i++) send(i == 16, rnd512());
    drain(); tick();
    chk("t5_err_set", len_err, 1'b1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t5_err_clr", len_err, 1'b0);
    for (int i = 0; i < 16; i++) send(i == 15, rnd512());
    drain(); tick();
    chk("t5_err_16ok", len_err, 1'b0);

    // Reset in the middle of a packet
    rq_out.tready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, rnd512());
    rq_out.tready = 1'b1; tick(); rq_out.tready = 1'b0; tick();
    chk("t6_pre_inpkt", pkt_active, 1'b1);
    chk("t6_pre_cnt",   fifo_cnt, 2'd2);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_vld",  rq_out.tvalid, 1'b0);
    chk("t6_rst_cnt",  fifo_cnt, 2'd0);
    chk("t6_rst_pkt",  pkt_active, 1'b0);
    chk("t6_rst_ptr",  trx_fifo_rd_ptr, 1'b0);
    chk("t6_rst_data", rq_out.tdata, '0);
    tick(); reset_n = 1'b1; rq_out.tready = 1'b1;
    repeat (5) tick();
    chk("t6_post_vld", rq_out.tvalid, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rq_in.tvalid  = ($urandom_range(0, 3) != 0);
      rq_in.tlast   = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      rq_in.tdata   = rnd512();
      rq_out.tready = ($urandom_range(0, 9) < 7);
      tx_hold       = ($urandom_range(0, 4) == 0);
      err_clr       = ($urandom_range(0, 19) == 0);
      tick();
    end
    rq_in.tvalid = 1'b0; err_clr = 1'b0;
    drain();
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
